mm2s_depacketizer: RTL and testbench
====================================

# mm2s_depacketizer

Receive-side counterpart of the ADC capture path. Accepts packets from the AXI DMA MM2S channel, checks each packet's length against a configured sample count, and forwards samples to a downstream sample consumer (DAC manager) through a one-stage register slice. The block regenerates `tlast` on the consumer side, counts packets, and flags short and long packets. It is configured and monitored over AXI4-Lite.

## Interface

- No parameters. Data width is fixed at 32.
- `aclk` in 1: clock for all logic.
- `areset` in 1: already decided as one clock, reset synchronous and active-high.
- `s_axis_mm2s_tdata/tvalid/tready/tlast` in/in/out/in 32/1/1/1: MM2S stream from the DMA.
- `m_axis_data_tdata/tvalid/tready/tlast` out/out/in/out 32/1/1/1: sample stream to the consumer.
- `last` out 1: copy of `m_axis_data_tlast & m_axis_data_tvalid & m_axis_data_tready`.
- `error` out 1: one-cycle pulse when a length error is detected.
- `s_axi_lite_*` out/in 32-bit address and data: full AXI4-Lite subordinate with `aw`, `w`, `b`, `ar` and `r` channels; `awprot`/`arprot` are ignored.

## Operation

- Registers are decoded on address bits [11:2]:
  - 0x200 `LEN` (RW): expected beats per packet.
  - 0x204 `BEAT` (RO): current beat index.
  - 0x208 `PKT` (RO): 16-bit packet count, zero-extended.
  - 0x20C `STAT` (bit0 `short_err`, bit1 `long_err`): sticky, write-1-to-clear.
- Unmapped addresses, and writes to RO registers, return SLVERR (2'b10). All other accesses return OKAY. Writes honour `wstrb`.
- `LEN` is copied to the active length `act_len` only when `BEAT==0` and no beat is being accepted in that cycle.
- FSM states:
  - `DISABLED`: `act_len==0`. `s_axis_mm2s_tready=0`, output idle. Moves to `RUN` when `act_len!=0`.
  - `RUN`: forwards each beat.
    - Beat index `act_len-1` with `tlast`: packet OK. `PKT++`, `BEAT<=0`, output `tlast=1`.
    - Beat index `act_len-1` without `tlast`: output `tlast=1`, `long_err` set, `error` pulses, then go to `DRAIN`.
    - `tlast` at index `<act_len-1`: `short_err` set, `error` pulses, beat forwarded with output `tlast=0`, then go to `PAD` (macro on) or reset `BEAT` (macro off).
  - `DRAIN`: `tready=1`, beats are discarded and not forwarded. On `tlast`, `PKT++`, `BEAT<=0`, return to `RUN`.
  - `PAD`: input `tready=0`. Zero beats are emitted until index `act_len-1`, which carries `tlast=1`. Then `PKT++` and return to `RUN`.
- `PKT` wraps from 0xFFFF to 0. `BEAT` is 32-bit and compared against `act_len-1`.
- `act_len==1`: every beat is a complete packet, so `tlast` is expected on every beat.

## Timing

- Reset values: all tvalid/tready/tlast, `bvalid`, `rvalid`, `last` and `error` are 0; `LEN`, `act_len`, `BEAT`, `PKT` and `STAT` are 0; FSM is in `DISABLED`; `awready`, `wready` and `arready` are 0.
- Latency is 1 cycle from input handshake to `m_axis_data_tvalid`.
- In `RUN`: `s_axis_mm2s_tready = !out_valid | m_axis_data_tready`. Full throughput, one beat per cycle.
- Output data is held stable while `tvalid & !tready`.
- AXI4-Lite write: `awready` and `wready` pulse together for one cycle only when `awvalid & wvalid & !bvalid`. `bvalid` rises the next cycle and holds until `bready`.
- AXI4-Lite read: `arready` is high when `!rvalid`. `rdata`/`rresp` are registered with `rvalid` the next cycle and held until `rready`.
- Simultaneous W1C write and error set in the same cycle: the set wins.
- A `LEN` write mid-packet does not affect the current packet.
- Reset mid-packet drops the in-flight beat. The DMA must be reset alongside the block.

## Configuration

- `MM2S_DEPACKETIZER_PAD_EN` defined: the `PAD` state exists, and short packets are zero-padded to `act_len` beats, so the consumer always sees fixed-length packets.
- Undefined: no `PAD` state. After a short packet, `BEAT<=0`, `PKT++`, and the FSM stays in `RUN`; the consumer sees a truncated packet with no `tlast`.

## Structure

- Package `mm2s_depacketizer_pkg` holds:
  - register offsets;
  - the FSM state enum (`DISABLED`, `RUN`, `DRAIN`, `PAD`);
  - AXI response codes OKAY/SLVERR.
- Top level holds the AXI4-Lite register file.
- Sub-module `mm2s_depacketizer_core` holds the FSM, counters and output slice.

## Test plan

- `LEN=4`; send 3 packets of 4 beats (data 0x10..0x1B) with `m_tready=1` → output matches input, `tlast` on beats 3/7/11, `PKT=3`, `STAT=0`.
- `LEN=4`; send a 2-beat packet with `tlast` → `STAT=1`, one `error` pulse. Macro on: output is data0, data1, 0, 0 with `tlast` on the 4th beat. Macro off: 2 beats, no `tlast`.
- `LEN=4`; send 6 beats with `tlast` on the 6th → 4 beats forwarded with `tlast` on the 4th, beats 5–6 discarded, `STAT=2`, `PKT=1`.
- `LEN=0` → `s_tready=0` for 20 cycles. Write `LEN=2` → traffic flows.
- Random `m_tready` backpressure at 50% over 100 beats with `LEN=5` → no loss or duplication, data stable under stall.
- Read 0x300 → `rresp=2'b10`. Write `PKT` → `bresp=2'b10`. Write `STAT=3` → `STAT` reads 0.

Source files
------------

// File: rtl/mm2s_depacketizer_pkg.sv
// rtl/mm2s_depacketizer_pkg.sv - register map, FSM states and AXI response codes
package mm2s_depacketizer_pkg;

  localparam logic [11:0] REG_LEN  = 12'h200;
  localparam logic [11:0] REG_BEAT = 12'h204;
  localparam logic [11:0] REG_PKT  = 12'h208;
  localparam logic [11:0] REG_STAT = 12'h20C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    DISABLED,
    RUN,
    DRAIN,
    PAD
  } state_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mm2s_depacketizer_core.sv
// rtl/mm2s_depacketizer_core.sv - length-checking FSM, counters and output slice
// Optional zero-padding of short packets: MM2S_DEPACKETIZER_PAD_EN.
module mm2s_depacketizer_core
  import mm2s_depacketizer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] len_i,
  input  logic [31:0] s_tdata_i,
  input  logic        s_tvalid_i,
  output logic        s_tready_o,
  input  logic        s_tlast_i,
  output logic [31:0] m_tdata_o,
  output logic        m_tvalid_o,
  input  logic        m_tready_i,
  output logic        m_tlast_o,
  output logic [31:0] beat_o,
  output logic [15:0] pkt_o,
  output logic        short_err_o,
  output logic        long_err_o,
  output logic        error_o
);

  state_e      state_q;
  logic [31:0] act_len_q, beat_q, out_data_q;
  logic [15:0] pkt_q;
  logic        out_valid_q, out_last_q, short_q, long_q;
  logic        can_load, s_ready, s_fire, at_end;

  assign can_load = !out_valid_q || m_tready_i;
  assign at_end   = (beat_q == act_len_q - 32'd1);
  assign s_fire   = s_tvalid_i && s_ready;

  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      RUN:     s_ready = can_load && (act_len_q != 32'd0);
      DRAIN:   s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= DISABLED;
      act_len_q   <= '0;
      beat_q      <= '0;
      pkt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      short_q <= 1'b0;
      long_q  <= 1'b0;
      if (m_tready_i) out_valid_q <= 1'b0;
      // Length only changes between packets so an in-flight packet keeps its size.
      if (beat_q == 32'd0 && !s_fire && (state_q == DISABLED || state_q == RUN))
        act_len_q <= len_i;
      case (state_q)
        DISABLED: if (act_len_q != 32'd0) state_q <= RUN;
        RUN: begin
          if (act_len_q == 32'd0) begin
            state_q <= DISABLED;
          end else if (s_fire) begin
            out_valid_q <= 1'b1;
            out_data_q  <= s_tdata_i;
            out_last_q  <= at_end;
            if (at_end && s_tlast_i) begin
              beat_q <= '0;
              pkt_q  <= pkt_q + 16'd1;
            end else if (at_end) begin
              long_q  <= 1'b1;
              beat_q  <= beat_q + 32'd1;
              state_q <= DRAIN;
            end else if (s_tlast_i) begin
              short_q <= 1'b1;
`ifdef MM2S_DEPACKETIZER_PAD_EN
              beat_q  <= beat_q + 32'd1;
              state_q <= PAD;
`else
              beat_q  <= '0;
              pkt_q   <= pkt_q + 16'd1;
`endif
            end else begin
              beat_q <= beat_q + 32'd1;
            end
          end
        end
        DRAIN: begin
          if (s_tvalid_i) begin
            if (s_tlast_i) begin
              beat_q  <= '0;
              pkt_q   <= pkt_q + 16'd1;
              state_q <= RUN;
            end else begin
              beat_q <= beat_q + 32'd1;
            end
          end
        end
        PAD: begin
`ifdef MM2S_DEPACKETIZER_PAD_EN
          if (can_load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= '0;
            out_last_q  <= at_end;
            if (at_end) begin
              beat_q  <= '0;
              pkt_q   <= pkt_q + 16'd1;
              state_q <= RUN;
            end else begin
              beat_q <= beat_q + 32'd1;
            end
          end
`else
          state_q <= RUN;
`endif
        end
        default: state_q <= DISABLED;
      endcase
    end
  end

  assign s_tready_o  = s_ready;
  assign m_tdata_o   = out_data_q;
  assign m_tvalid_o  = out_valid_q;
  assign m_tlast_o   = out_last_q;
  assign beat_o      = beat_q;
  assign pkt_o       = pkt_q;
  assign short_err_o = short_q;
  assign long_err_o  = long_q;
  assign error_o     = short_q || long_q;

endmodule

// File: rtl/mm2s_depacketizer.sv
// rtl/mm2s_depacketizer.sv - MM2S depacketizer top with AXI4-Lite register file
// Optional zero-padding of short packets: MM2S_DEPACKETIZER_PAD_EN.
module mm2s_depacketizer
  import mm2s_depacketizer_pkg::*;
(
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] s_axis_mm2s_tdata,
  input  logic        s_axis_mm2s_tvalid,
  output logic        s_axis_mm2s_tready,
  input  logic        s_axis_mm2s_tlast,
  output logic [31:0] m_axis_data_tdata,
  output logic        m_axis_data_tvalid,
  input  logic        m_axis_data_tready,
  output logic        m_axis_data_tlast,
  output logic        last,
  output logic        error,
  input  logic [31:0] s_axi_lite_awaddr,
  input  logic [2:0]  s_axi_lite_awprot,
  input  logic        s_axi_lite_awvalid,
  output logic        s_axi_lite_awready,
  input  logic [31:0] s_axi_lite_wdata,
  input  logic [3:0]  s_axi_lite_wstrb,
  input  logic        s_axi_lite_wvalid,
  output logic        s_axi_lite_wready,
  output logic [1:0]  s_axi_lite_bresp,
  output logic        s_axi_lite_bvalid,
  input  logic        s_axi_lite_bready,
  input  logic [31:0] s_axi_lite_araddr,
  input  logic [2:0]  s_axi_lite_arprot,
  input  logic        s_axi_lite_arvalid,
  output logic        s_axi_lite_arready,
  output logic [31:0] s_axi_lite_rdata,
  output logic [1:0]  s_axi_lite_rresp,
  output logic        s_axi_lite_rvalid,
  input  logic        s_axi_lite_rready
);

  logic [31:0] len_q, beat, rd_data;
  logic [15:0] pkt;
  logic [1:0]  stat_q, stat_d, bresp_q, rresp_q, wr_resp, rd_resp;
  logic [31:0] rdata_q;
  logic        bvalid_q, rvalid_q, ready_q, wr_fire, rd_fire;
  logic        short_err, long_err;
  logic        unused_bits;

  assign unused_bits = ^{s_axi_lite_awprot, s_axi_lite_arprot,
                         s_axi_lite_awaddr[31:12], s_axi_lite_awaddr[1:0],
                         s_axi_lite_araddr[31:12], s_axi_lite_araddr[1:0]};

  // ready_q keeps all handshakes closed while in reset.
  assign wr_fire = ready_q && s_axi_lite_awvalid && s_axi_lite_wvalid && !bvalid_q;
  assign rd_fire = ready_q && s_axi_lite_arvalid && !rvalid_q;

  always_comb begin
    wr_resp = RESP_SLVERR;
    case (s_axi_lite_awaddr[11:2])
      REG_LEN[11:2], REG_STAT[11:2]: wr_resp = RESP_OKAY;
      default:                       wr_resp = RESP_SLVERR;
    endcase
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (s_axi_lite_araddr[11:2])
      REG_LEN[11:2]:  rd_data = len_q;
      REG_BEAT[11:2]: rd_data = beat;
      REG_PKT[11:2]:  rd_data = {16'd0, pkt};
      REG_STAT[11:2]: rd_data = {30'd0, stat_q};
      default:        rd_resp = RESP_SLVERR;
    endcase
  end

  always_comb begin
    stat_d = stat_q;
    if (wr_fire && s_axi_lite_awaddr[11:2] == REG_STAT[11:2] && s_axi_lite_wstrb[0])
      stat_d = stat_q & ~s_axi_lite_wdata[1:0];
    stat_d = stat_d | {long_err, short_err};
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      ready_q  <= 1'b0;
      len_q    <= '0;
      stat_q   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      ready_q <= 1'b1;
      stat_q  <= stat_d;
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
        if (s_axi_lite_awaddr[11:2] == REG_LEN[11:2])
          len_q <= apply_wstrb(len_q, s_axi_lite_wdata, s_axi_lite_wstrb);
      end else if (s_axi_lite_bready) begin
        bvalid_q <= 1'b0;
      end
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_resp;
      end else if (s_axi_lite_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign s_axi_lite_awready = wr_fire;
  assign s_axi_lite_wready  = wr_fire;
  assign s_axi_lite_bvalid  = bvalid_q;
  assign s_axi_lite_bresp   = bresp_q;
  assign s_axi_lite_arready = ready_q && !rvalid_q;
  assign s_axi_lite_rvalid  = rvalid_q;
  assign s_axi_lite_rdata   = rdata_q;
  assign s_axi_lite_rresp   = rresp_q;

  mm2s_depacketizer_core u_core (
    .clk_i       (aclk),
    .rst_i       (areset),
    .len_i       (len_q),
    .s_tdata_i   (s_axis_mm2s_tdata),
    .s_tvalid_i  (s_axis_mm2s_tvalid),
    .s_tready_o  (s_axis_mm2s_tready),
    .s_tlast_i   (s_axis_mm2s_tlast),
    .m_tdata_o   (m_axis_data_tdata),
    .m_tvalid_o  (m_axis_data_tvalid),
    .m_tready_i  (m_axis_data_tready),
    .m_tlast_o   (m_axis_data_tlast),
    .beat_o      (beat),
    .pkt_o       (pkt),
    .short_err_o (short_err),
    .long_err_o  (long_err),
    .error_o     (error)
  );

  assign last = m_axis_data_tlast && m_axis_data_tvalid && m_axis_data_tready;

endmodule

// File: tb/tb_mm2s_depacketizer.sv
// tb/tb_mm2s_depacketizer.sv - directed self-checking bench for mm2s_depacketizer
module tb_mm2s_depacketizer;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] s_tdata, m_tdata;
  logic        s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;
  logic        last, error;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;

  int n_checks = 0;
  int n_pass = 0;
  int err_cnt = 0;
  int last_cnt = 0;
  int stall_err = 0;
  bit rnd_en = 0;
  logic [32:0] obs_q[$];
  logic [32:0] exp_q[$];

  always #5 aclk = ~aclk;

  mm2s_depacketizer dut (
    .aclk(aclk), .areset(areset),
    .s_axis_mm2s_tdata(s_tdata), .s_axis_mm2s_tvalid(s_tvalid),
    .s_axis_mm2s_tready(s_tready), .s_axis_mm2s_tlast(s_tlast),
    .m_axis_data_tdata(m_tdata), .m_axis_data_tvalid(m_tvalid),
    .m_axis_data_tready(m_tready), .m_axis_data_tlast(m_tlast),
    .last(last), .error(error),
    .s_axi_lite_awaddr(awaddr), .s_axi_lite_awprot(awprot),
    .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
    .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb),
    .s_axi_lite_wvalid(wvalid), .s_axi_lite_wready(wready),
    .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid), .s_axi_lite_bready(bready),
    .s_axi_lite_araddr(araddr), .s_axi_lite_arprot(arprot),
    .s_axi_lite_arvalid(arvalid), .s_axi_lite_arready(arready),
    .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp),
    .s_axi_lite_rvalid(rvalid), .s_axi_lite_rready(rready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [1:0] resp);
    bit done;
    done = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge aclk); done = awready && wready;
      @(posedge aclk); #1;
    end
    awvalid = 0; wvalid = 0;
    check("aw_handshake", done, 1);
    done = 0; resp = 2'b11; bready = 1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge aclk); if (bvalid) begin done = 1; resp = bresp; end
      @(posedge aclk); #1;
    end
    bready = 0;
    check("b_handshake", done, 1);
  endtask

  task automatic axi_rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit done;
    done = 0;
    araddr = a; arvalid = 1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge aclk); done = arready;
      @(posedge aclk); #1;
    end
    arvalid = 0;
    check("ar_handshake", done, 1);
    done = 0; d = 32'hDEAD_BEEF; resp = 2'b11; rready = 1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge aclk); if (rvalid) begin done = 1; d = rdata; resp = rresp; end
      @(posedge aclk); #1;
    end
    rready = 0;
    check("r_handshake", done, 1);
  endtask

  task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_rd(a, d, r);
    check(tag, d, exp);
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    bit done;
    done = 0;
    s_tdata = d; s_tlast = l; s_tvalid = 1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge aclk); done = s_tready;
      @(posedge aclk); #1;
    end
    s_tvalid = 0;
    if (!done) check("send_timeout", done, 1);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  // Output monitor: sample handshakes, pulses and stall stability mid-cycle.
  initial begin
    logic        stall_q;
    logic [32:0] stall_v;
    stall_q = 0;
    stall_v = '0;
    forever begin
      @(negedge aclk);
      if (!areset) begin
        if (m_tvalid && m_tready) obs_q.push_back({m_tlast, m_tdata});
        if (error) err_cnt++;
        if (last) last_cnt++;
        if (stall_q && (!m_tvalid || {m_tlast, m_tdata} !== stall_v)) stall_err++;
        stall_q = m_tvalid && !m_tready;
        stall_v = {m_tlast, m_tdata};
      end
    end
  end

  initial forever begin
    @(posedge aclk); #1;
    if (rnd_en) m_tready = 1'($urandom_range(0, 1));
  end

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    int          hi;
    areset = 1; s_tdata = 0; s_tvalid = 0; s_tlast = 0; m_tready = 1;
    awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arprot = 0; arvalid = 0; rready = 0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_bvalid_rvalid", {bvalid, rvalid}, 0);
    check("rst_readies", {awready, wready, arready}, 0);
    check("rst_error_last", {error, last}, 0);
    @(posedge aclk); #1;
    areset = 0;
    check_reg("rst_len", 32'h200, 0);
    check_reg("rst_beat", 32'h204, 0);
    check_reg("rst_pkt", 32'h208, 0);
    check_reg("rst_stat", 32'h20C, 0);

    // Three well-formed packets of four beats.
    axi_wr(32'h200, 32'd4, 4'hF, r);
    check("len_bresp", r, 2'b00);
    last_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      send(32'h10 + i, (i % 4) == 3);
      exp_q.push_back({(i % 4) == 3, 32'h10 + i});
    end
    repeat (5) @(posedge aclk); #1;
    check_stream("good");
    check("good_last_pulses", last_cnt, 3);
    check("good_errors", err_cnt, 0);
    check_reg("good_pkt", 32'h208, 3);
    check_reg("good_stat", 32'h20C, 0);

    // Short packet: two beats with tlast on the second.
    err_cnt = 0;
    send(32'h20, 0);
    send(32'h21, 1);
    repeat (8) @(posedge aclk); #1;
    exp_q.push_back({1'b0, 32'h20});
    exp_q.push_back({1'b0, 32'h21});
`ifdef MM2S_DEPACKETIZER_PAD_EN
    exp_q.push_back({1'b0, 32'h0});
    exp_q.push_back({1'b1, 32'h0});
`endif
    check_stream("short");
    check("short_errors", err_cnt, 1);
    check_reg("short_stat", 32'h20C, 1);
    check_reg("short_pkt", 32'h208, 4);
    check_reg("short_beat", 32'h204, 0);
    axi_wr(32'h20C, 32'd1, 4'hF, r);
    check_reg("short_stat_clr", 32'h20C, 0);

    // Long packet: six beats, last two must be discarded.
    err_cnt = 0;
    for (int i = 0; i < 6; i++) send(32'h30 + i, i == 5);
    for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, 32'h30 + i});
    repeat (5) @(posedge aclk); #1;
    check_stream("long");
    check("long_errors", err_cnt, 1);
    check_reg("long_stat", 32'h20C, 2);
    check_reg("long_pkt", 32'h208, 5);
    axi_wr(32'h20C, 32'd3, 4'hF, r);
    check("stat_w1c_bresp", r, 2'b00);
    check_reg("long_stat_clr", 32'h20C, 0);

    // LEN=0 disables the input; LEN=2 restarts traffic.
    axi_wr(32'h200, 32'd0, 4'hF, r);
    repeat (3) @(posedge aclk); #1;
    s_tdata = 32'h77; s_tvalid = 1; s_tlast = 0;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk); if (s_tready) hi++;
    end
    @(posedge aclk); #1;
    s_tvalid = 0;
    check("disabled_tready_cycles", hi, 0);
    check("disabled_no_output", obs_q.size(), 0);
    axi_wr(32'h200, 32'd2, 4'hF, r);
    send(32'h40, 0);
    send(32'h41, 1);
    repeat (5) @(posedge aclk); #1;
    exp_q.push_back({1'b0, 32'h40});
    exp_q.push_back({1'b1, 32'h41});
    check_stream("len2");
    check_reg("len2_pkt", 32'h208, 6);

    // Random backpressure, LEN=5, 100 beats.
    axi_wr(32'h200, 32'd5, 4'hF, r);
    repeat (3) @(posedge aclk); #1;
    last_cnt = 0; err_cnt = 0; stall_err = 0;
    rnd_en = 1;
    for (int i = 0; i < 100; i++) begin
      send(32'h1000 + i, (i % 5) == 4);
      exp_q.push_back({(i % 5) == 4, 32'h1000 + i});
    end
    rnd_en = 0;
    @(posedge aclk); #2;
    m_tready = 1;
    repeat (5) @(posedge aclk); #1;
    check_stream("bp");
    check("bp_stall_stable", stall_err, 0);
    check("bp_last_pulses", last_cnt, 20);
    check("bp_errors", err_cnt, 0);
    check_reg("bp_pkt", 32'h208, 26);

    // Register map error responses and byte strobes.
    axi_rd(32'h300, d, r);
    check("unmapped_rresp", r, 2'b10);
    axi_wr(32'h208, 32'd9, 4'hF, r);
    check("pkt_write_bresp", r, 2'b10);
    check_reg("pkt_unchanged", 32'h208, 26);
    axi_wr(32'h204, 32'd9, 4'hF, r);
    check("beat_write_bresp", r, 2'b10);
    axi_wr(32'h200, 32'hAABB_CCDD, 4'b0101, r);
    check_reg("len_wstrb", 32'h200, 32'h00BB_00DD);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
